// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: d = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop; result committed on the last bit.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic x, y, diff, br_nx;
  logic [W-1:0] res_sh;

  assign x      = a_q[0];
  assign y      = b_q[0];
  assign diff   = x ^ y ^ br_q;
  assign br_nx  = (~x & y) | (~(x ^ y) & br_q);
  assign res_sh = {diff, res_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    bout_d  = bout_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        res_d = res_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = res_sh;
          bout_d  = br_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor. It computes d = a - b - bin over W clock cycles, one bit per cycle, LSB first. It uses a single full-subtractor cell and a borrow flip-flop. It is the inverse operation of the team's parallel four-bit adder and trades area for latency. It sits between operand registers and a result consumer, and uses a start/done handshake.

Parameters:
W, 4, operand and result width in bits (W >= 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when not busy
a  input  W  minuend; sampled on the accepted start edge
b  input  W  subtrahend; sampled on the accepted start edge
bin  input  1  borrow-in; sampled on the accepted start edge
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse: d and bout are valid
d  output  W  difference (a - b - bin) mod 2^W
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- rst=1 at an edge sets: state=IDLE, busy=0, done=0, d=0, bout=0, internal shift registers=0, bit counter=0, borrow flop=0.
- rst has priority over start and over any in-flight operation. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE -> SHIFT on start=1. At the same edge, latch a, b into shift regs, latch bin into the borrow flop, and clear the counter.
  - SHIFT stays in SHIFT while counter < W-1. Each edge processes one bit (counter increments).
  - SHIFT -> DONE on the edge that processes bit W-1.
  - DONE -> IDLE if start=0.
  - DONE -> SHIFT if start=1 (back-to-back accept, with latching as in IDLE).
- Per-bit cell, with x = current a bit, y = current b bit, br = borrow flop:
  - diff = x ^ y ^ br
  - borrow_next = (~x & y) | (~(x ^ y) & br)
  - The diff bit shifts into the result register from the MSB side. After W shifts, bit 0 sits at the LSB.
  - The a and b shift registers shift right by one.
- Latency: start accepted at edge 0. Bits are processed on edges 1..W. done=1 in the cycle after edge W. Start-to-done is W+1 edges.
- d and bout update only on the final SHIFT edge. They hold their values through DONE and IDLE until the next operation's final edge. During SHIFT, d holds the previous result and does not expose partial values (use a separate working register).
- start while busy=1 is ignored; latched operands are unaffected. start has no effect in the same cycle rst=1.
- a, b and bin may change freely after the accept edge.
- No signed interpretation. Overflow is reported only through bout.

Test Plan:
- Reset, then a=5, b=3, bin=0, start for 1 cycle -> busy high 4 cycles; done pulses once 5 edges after accept; d=4'b0010, bout=0.
- a=3, b=5, bin=0 -> d=4'b1110, bout=1.
- a=0, b=0, bin=1 -> d=4'b1111, bout=1. Then a=15, b=15, bin=0 -> d=0, bout=0. Sweep all 512 (a, b, bin) combos for W=4 against the behavioural model a-b-bin.
- Start pulse with a=9, b=2 mid-operation of a=7, b=1 -> ignored; result is d=6, bout=0 and done pulses only once.
- start held high at the DONE cycle with new a=12, b=4 -> first done (prior result), then a second done exactly 5 edges later with d=8, bout=0; no IDLE cycle between.
- rst asserted on the 2nd SHIFT cycle -> next cycle busy=0, done=0, d=0, bout=0. No done pulse follows. A subsequent operation (a=10, b=10) gives d=0, bout=0.
